// File: rtl/bypass_forward_ctrl.sv
// -----------------------------------------------------------------------------
// bypass_forward_ctrl
//   Hazard resolver for the five-stage core. It tracks the instruction words in
//   the DX, XM and MW latches and drives the stage-advance enables. It also
//   produces the ALU and store-data forwarding selects and runs the
//   multiply/divide start/ready handshake, freezing the front of the pipe while
//   the unit is busy.
//
//   Optional feature macro: BYPASS_MW_EN
//     defined   : MW-stage forwarding enabled (selects may be 2'b10, and
//                 sel_st_xm is active)
//     undefined : only XM forwarding; sel_st_xm tied low
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   fd_insn    in   [31:0] instruction in the FD latch
//   stall_in   in   load-use stall request (same cycle)
//   flush      in   taken branch/jump resolved in X
//   md_ready   in   multdiv result valid pulse
//   pc_we      out  PC write enable                      (combinational)
//   fd_we      out  FD latch write enable                (combinational)
//   md_start   out  one-cycle multdiv start pulse        (combinational)
//   dx_insn    out  [31:0] DX latch instruction          (registered)
//   xm_insn    out  [31:0] XM latch instruction          (registered)
//   mw_insn    out  [31:0] MW latch instruction          (registered)
//   sel_a      out  [1:0] ALU A select: 00 rf, 01 XM, 10 MW   (combinational)
//   sel_b      out  [1:0] ALU B / store-data select           (combinational)
//   sel_st_xm  out  XM store data taken from MW writeback     (combinational)
// -----------------------------------------------------------------------------
module bypass_forward_ctrl #(
   parameter logic [31:0] BUBBLE = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] fd_insn,
   input  logic        stall_in,
   input  logic        flush,
   input  logic        md_ready,
   output logic        pc_we,
   output logic        fd_we,
   output logic        md_start,
   output logic [31:0] dx_insn,
   output logic [31:0] xm_insn,
   output logic [31:0] mw_insn,
   output logic [1:0]  sel_a,
   output logic [1:0]  sel_b,
   output logic        sel_st_xm
);

   localparam int unsigned FLD_W = 5;

   localparam logic [FLD_W-1:0] OP_RTYPE = 5'b00000;
   localparam logic [FLD_W-1:0] OP_BNE   = 5'b00010;
   localparam logic [FLD_W-1:0] OP_ADDI  = 5'b00101;
   localparam logic [FLD_W-1:0] OP_BLT   = 5'b00110;
   localparam logic [FLD_W-1:0] OP_SW    = 5'b00111;
   localparam logic [FLD_W-1:0] OP_LW    = 5'b01000;
   localparam logic [FLD_W-1:0] ALU_MUL  = 5'b00110;
   localparam logic [FLD_W-1:0] ALU_DIV  = 5'b00111;

   localparam logic [1:0] SEL_RF = 2'b00;
   localparam logic [1:0] SEL_XM = 2'b01;
`ifdef BYPASS_MW_EN
   localparam logic [1:0] SEL_MW = 2'b10;
`endif

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   // Opcodes whose rd is written back to the register file.
   function automatic logic writes_rd(input logic [FLD_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW);
   endfunction

   state_t      state_q, state_d;
   logic        issued_q, issued_d;
   logic [31:0] dx_q, dx_d;
   logic [31:0] xm_q, xm_d;
   logic [31:0] mw_q, mw_d;

   assign dx_insn = dx_q;
   assign xm_insn = xm_q;
   assign mw_insn = mw_q;

   // Field extraction for the latches that feed forwarding decisions.
   logic [FLD_W-1:0] dx_op, dx_rd, dx_rs, dx_rt, dx_alu;
   logic [FLD_W-1:0] xm_op, xm_rd;
   logic             xm_wr;

   assign dx_op  = dx_q[31:27];
   assign dx_rd  = dx_q[26:22];
   assign dx_rs  = dx_q[21:17];
   assign dx_rt  = dx_q[16:12];
   assign dx_alu = dx_q[6:2];
   assign xm_op  = xm_q[31:27];
   assign xm_rd  = xm_q[26:22];
   // $r0 is hardwired, so a write to it never produces a forwardable value.
   assign xm_wr  = writes_rd(xm_op) && (xm_rd != '0);

`ifdef BYPASS_MW_EN
   logic [FLD_W-1:0] mw_op, mw_rd;
   logic             mw_wr;

   assign mw_op = mw_q[31:27];
   assign mw_rd = mw_q[26:22];
   assign mw_wr = writes_rd(mw_op) && (mw_rd != '0);
`endif

   // B operand source: rt for R-type, rd for stores and compare branches.
   logic             b_used;
   logic [FLD_W-1:0] b_reg;

   always_comb begin
      b_used = 1'b0;
      b_reg  = dx_rt;
      case (dx_op)
         OP_RTYPE: begin
            b_used = 1'b1;
            b_reg  = dx_rt;
         end
         OP_SW, OP_BNE, OP_BLT: begin
            b_used = 1'b1;
            b_reg  = dx_rd;
         end
         default: begin
            b_used = 1'b0;
            b_reg  = dx_rt;
         end
      endcase
   end

   // Forwarding selects; the younger XM result takes priority over MW.
   always_comb begin
      sel_a     = SEL_RF;
      sel_b     = SEL_RF;
      sel_st_xm = 1'b0;
      if (xm_wr && (xm_rd == dx_rs)) begin
         sel_a = SEL_XM;
      end
`ifdef BYPASS_MW_EN
      else if (mw_wr && (mw_rd == dx_rs)) begin
         sel_a = SEL_MW;
      end
`endif
      if (b_used && xm_wr && (xm_rd == b_reg)) begin
         sel_b = SEL_XM;
      end
`ifdef BYPASS_MW_EN
      else if (b_used && mw_wr && (mw_rd == b_reg)) begin
         sel_b = SEL_MW;
      end
      // lw followed by sw of the loaded register: store data comes from MW.
      sel_st_xm = (xm_op == OP_SW) && mw_wr && (mw_rd == xm_rd);
`endif
   end

   logic dx_is_md;
   assign dx_is_md = (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));

   // Advance control and next-state for the pipeline latches.
   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      dx_d     = dx_q;
      xm_d     = dx_q;
      mw_d     = xm_q;
      pc_we    = 1'b1;
      fd_we    = 1'b1;
      md_start = 1'b0;

      if (state_q == RUN) begin
         if (flush) begin
            dx_d     = BUBBLE;
            issued_d = 1'b0;
         end else if (dx_is_md && !issued_q) begin
            md_start = 1'b1;
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            xm_d     = BUBBLE;
            issued_d = 1'b1;
            state_d  = MD_WAIT;
         end else if (stall_in) begin
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            dx_d     = BUBBLE;
            issued_d = 1'b0;
         end else begin
            dx_d     = fd_insn;
            issued_d = 1'b0;
         end
      end else begin
         // Front frozen; flush cannot occur here since X holds no branch.
         pc_we = 1'b0;
         fd_we = 1'b0;
         xm_d  = BUBBLE;
         if (md_ready) begin
            // Exit and advance on the same edge, so there is no exit penalty.
            state_d  = RUN;
            xm_d     = dx_q;
            issued_d = 1'b0;
            if (stall_in) begin
               dx_d = BUBBLE;
            end else begin
               pc_we = 1'b1;
               fd_we = 1'b1;
               dx_d  = fd_insn;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         issued_q <= 1'b0;
         dx_q     <= BUBBLE;
         xm_q     <= BUBBLE;
         mw_q     <= BUBBLE;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         dx_q     <= dx_d;
         xm_q     <= xm_d;
         mw_q     <= mw_d;
      end
   end

endmodule

// File: tb/tb_bypass_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bypass_forward_ctrl
//   Directed-vector bench for bypass_forward_ctrl. Each vector drives one
//   cycle of inputs and queues the hand-computed outputs for that cycle; a
//   monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_bypass_forward_ctrl;

   logic        clock;
   logic        reset;
   logic [31:0] fd_insn;
   logic        stall_in;
   logic        flush;
   logic        md_ready;
   logic        pc_we;
   logic        fd_we;
   logic        md_start;
   logic [31:0] dx_insn;
   logic [31:0] xm_insn;
   logic [31:0] mw_insn;
   logic [1:0]  sel_a;
   logic [1:0]  sel_b;
   logic        sel_st_xm;

   bypass_forward_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .fd_insn   (fd_insn),
      .stall_in  (stall_in),
      .flush     (flush),
      .md_ready  (md_ready),
      .pc_we     (pc_we),
      .fd_we     (fd_we),
      .md_start  (md_start),
      .dx_insn   (dx_insn),
      .xm_insn   (xm_insn),
      .mw_insn   (mw_insn),
      .sel_a     (sel_a),
      .sel_b     (sel_b),
      .sel_st_xm (sel_st_xm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction words: {op, rd, rs, rt, shamt, aluop, 2'b00} / {op, rd, rs, imm17}
   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] ADD1   = {5'd0, 5'd1,  5'd2, 5'd3,  5'd0, 5'b00000, 2'd0}; // add $1,$2,$3
   localparam logic [31:0] SUB4   = {5'd0, 5'd4,  5'd1, 5'd5,  5'd0, 5'b00001, 2'd0}; // sub $4,$1,$5
   localparam logic [31:0] OR6    = {5'd0, 5'd6,  5'd7, 5'd1,  5'd0, 5'b00011, 2'd0}; // or  $6,$7,$1
   localparam logic [31:0] LW3    = {5'b01000, 5'd3, 5'd2, 17'd0};                   // lw  $3,0($2)
   localparam logic [31:0] ADDLU  = {5'd0, 5'd8,  5'd3, 5'd9,  5'd0, 5'b00000, 2'd0}; // add $8,$3,$9
   localparam logic [31:0] MUL5   = {5'd0, 5'd5,  5'd6, 5'd7,  5'd0, 5'b00110, 2'd0}; // mul $5,$6,$7
   localparam logic [31:0] FDX    = {5'd0, 5'd11, 5'd5, 5'd13, 5'd0, 5'b00000, 2'd0}; // add $11,$5,$13
   localparam logic [31:0] ADDI0  = {5'b00101, 5'd0, 5'd1, 17'd5};                   // addi $0,$1,5
   localparam logic [31:0] ADD200 = {5'd0, 5'd2,  5'd0, 5'd0,  5'd0, 5'b00000, 2'd0}; // add $2,$0,$0
   localparam logic [31:0] LW10   = {5'b01000, 5'd10, 5'd2, 17'd0};                  // lw  $10,0($2)
   localparam logic [31:0] SW10   = {5'b00111, 5'd10, 5'd3, 17'd4};                  // sw  $10,4($3)
   localparam logic [31:0] ADD1B  = {5'd0, 5'd1,  5'd4, 5'd4,  5'd0, 5'b00000, 2'd0}; // add $1,$4,$4

   // MW-path expectations collapse to zero when MW forwarding is compiled out.
`ifdef BYPASS_MW_EN
   localparam logic [1:0] S_MW  = 2'b10;
   localparam logic       ST_MW = 1'b1;
`else
   localparam logic [1:0] S_MW  = 2'b00;
   localparam logic       ST_MW = 1'b0;
`endif

   typedef struct packed {
      logic        pc;
      logic        fdw;
      logic        mds;
      logic [31:0] dx;
      logic [31:0] xm;
      logic [31:0] mw;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic        sst;
   } exp_t;

   exp_t  exp_q[$];
   string nm_q[$];
   int    vectors     = 0;
   int    miscompares = 0;

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s.%s got %h expected %h", nm, fld, act, req);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   exp_t  mon_e;
   string mon_nm;
   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         mon_e  = exp_q.pop_front();
         mon_nm = nm_q.pop_front();
         vectors++;
         chk(mon_nm, "pc_we",     32'(pc_we),     32'(mon_e.pc));
         chk(mon_nm, "fd_we",     32'(fd_we),     32'(mon_e.fdw));
         chk(mon_nm, "md_start",  32'(md_start),  32'(mon_e.mds));
         chk(mon_nm, "dx_insn",   dx_insn,        mon_e.dx);
         chk(mon_nm, "xm_insn",   xm_insn,        mon_e.xm);
         chk(mon_nm, "mw_insn",   mw_insn,        mon_e.mw);
         chk(mon_nm, "sel_a",     32'(sel_a),     32'(mon_e.sa));
         chk(mon_nm, "sel_b",     32'(sel_b),     32'(mon_e.sb));
         chk(mon_nm, "sel_st_xm", 32'(sel_st_xm), 32'(mon_e.sst));
      end
   end

   // Drive one cycle of inputs just after the rising edge and queue its outputs.
   task automatic vec(input string nm, input logic [31:0] fd, input logic r,
                      input logic s, input logic f, input logic m,
                      input logic pc, input logic fdw, input logic mds,
                      input logic [31:0] dx, input logic [31:0] xm, input logic [31:0] mw,
                      input logic [1:0] sa, input logic [1:0] sb, input logic sst);
      exp_t e;
      @(posedge clock);
      #1;
      fd_insn  = fd;
      reset    = r;
      stall_in = s;
      flush    = f;
      md_ready = m;
      e = '{pc: pc, fdw: fdw, mds: mds, dx: dx, xm: xm, mw: mw, sa: sa, sb: sb, sst: sst};
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b1;
      fd_insn  = NOP;
      stall_in = 1'b0;
      flush    = 1'b0;
      md_ready = 1'b0;
      repeat (2) @(posedge clock);

      //  name                fd      r  s  f  m   pc fd md  dx      xm      mw      sa     sb     sst
      vec("reset_hold",       NOP,    1, 0, 0, 0,  1, 1, 0,  NOP,    NOP,    NOP,    2'b00, 2'b00, 0);
      vec("add_in_fd",        ADD1,   0, 0, 0, 0,  1, 1, 0,  NOP,    NOP,    NOP,    2'b00, 2'b00, 0);
      vec("add_in_dx",        SUB4,   0, 0, 0, 0,  1, 1, 0,  ADD1,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("sub_fwd_xm",       OR6,    0, 0, 0, 0,  1, 1, 0,  SUB4,   ADD1,   NOP,    2'b01, 2'b00, 0);
      vec("or_fwd_mw",        NOP,    0, 0, 0, 0,  1, 1, 0,  OR6,    SUB4,   ADD1,   2'b00, S_MW,  0);
      vec("lw_in_fd",         LW3,    0, 0, 0, 0,  1, 1, 0,  NOP,    OR6,    SUB4,   2'b00, 2'b00, 0);
      vec("load_use_stall",   ADDLU,  0, 1, 0, 0,  0, 0, 0,  LW3,    NOP,    OR6,    2'b00, 2'b00, 0);
      vec("after_bubble",     ADDLU,  0, 0, 0, 0,  1, 1, 0,  NOP,    LW3,    NOP,    2'b00, 2'b00, 0);
      vec("lu_fwd_mw",        NOP,    0, 0, 0, 0,  1, 1, 0,  ADDLU,  NOP,    LW3,    S_MW,  2'b00, 0);
      vec("mul_in_fd",        MUL5,   0, 0, 0, 0,  1, 1, 0,  NOP,    ADDLU,  NOP,    2'b00, 2'b00, 0);
      vec("md_start",         FDX,    0, 0, 0, 0,  0, 0, 1,  MUL5,   NOP,    ADDLU,  2'b00, 2'b00, 0);
      vec("md_wait_stall",    FDX,    0, 1, 0, 0,  0, 0, 0,  MUL5,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("md_wait_flush",    FDX,    0, 0, 1, 0,  0, 0, 0,  MUL5,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("md_wait",          FDX,    0, 0, 0, 0,  0, 0, 0,  MUL5,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("md_ready",         FDX,    0, 0, 0, 1,  1, 1, 0,  MUL5,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("mul_in_xm",        NOP,    0, 0, 0, 0,  1, 1, 0,  FDX,    MUL5,   NOP,    2'b01, 2'b00, 0);
      vec("mul2_in_fd",       MUL5,   0, 0, 0, 0,  1, 1, 0,  NOP,    FDX,    MUL5,   2'b00, 2'b00, 0);
      vec("mul2_start",       ADD1,   0, 0, 0, 0,  0, 0, 1,  MUL5,   NOP,    FDX,    2'b00, 2'b00, 0);
      vec("reset_mid_wait",   ADD1,   1, 0, 0, 0,  1, 1, 0,  NOP,    NOP,    NOP,    2'b00, 2'b00, 0);
      vec("late_md_ready",    ADD1,   0, 0, 0, 1,  1, 1, 0,  NOP,    NOP,    NOP,    2'b00, 2'b00, 0);
      vec("run_after_reset",  OR6,    0, 0, 0, 0,  1, 1, 0,  ADD1,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("flush_over_stall", SUB4,   0, 1, 1, 0,  1, 1, 0,  OR6,    ADD1,   NOP,    2'b00, 2'b01, 0);
      vec("after_flush",      NOP,    0, 0, 0, 0,  1, 1, 0,  NOP,    OR6,    ADD1,   2'b00, 2'b00, 0);
      vec("addi_r0_in_fd",    ADDI0,  0, 0, 0, 0,  1, 1, 0,  NOP,    NOP,    OR6,    2'b00, 2'b00, 0);
      vec("addi_r0_in_dx",    ADD200, 0, 0, 0, 0,  1, 1, 0,  ADDI0,  NOP,    NOP,    2'b00, 2'b00, 0);
      vec("r0_no_fwd_xm",     NOP,    0, 0, 0, 0,  1, 1, 0,  ADD200, ADDI0,  NOP,    2'b00, 2'b00, 0);
      vec("r0_no_fwd_mw",     NOP,    0, 0, 0, 0,  1, 1, 0,  NOP,    ADD200, ADDI0,  2'b00, 2'b00, 0);
      vec("lw10_in_fd",       LW10,   0, 0, 0, 0,  1, 1, 0,  NOP,    NOP,    ADD200, 2'b00, 2'b00, 0);
      vec("sw10_in_fd",       SW10,   0, 0, 0, 0,  1, 1, 0,  LW10,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("sw_data_fwd_xm",   NOP,    0, 0, 0, 0,  1, 1, 0,  SW10,   LW10,   NOP,    2'b00, 2'b01, 0);
      vec("sw_st_from_mw",    NOP,    0, 0, 0, 0,  1, 1, 0,  NOP,    SW10,   LW10,   2'b00, 2'b00, ST_MW);
      vec("sw_in_mw",         ADD1,   0, 0, 0, 0,  1, 1, 0,  NOP,    NOP,    SW10,   2'b00, 2'b00, 0);
      vec("dup_writer_a",     ADD1B,  0, 0, 0, 0,  1, 1, 0,  ADD1,   NOP,    NOP,    2'b00, 2'b00, 0);
      vec("dup_writer_b",     OR6,    0, 0, 0, 0,  1, 1, 0,  ADD1B,  ADD1,   NOP,    2'b00, 2'b00, 0);
      vec("xm_beats_mw",      NOP,    0, 0, 0, 0,  1, 1, 0,  OR6,    ADD1B,  ADD1,   2'b00, 2'b01, 0);
      vec("drain",            NOP,    0, 0, 0, 0,  1, 1, 0,  NOP,    OR6,    ADD1B,  2'b00, 2'b00, 0);

      @(posedge clock);
      @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
